// File: rtl/int_ctrl.sv
// Edge-triggered, prioritised interrupt controller that drives EXL/IV toward the main decoder.
// One interrupt is in service at a time; software sees CTRL, PEND, CAUSE and EOI on the register bus.
module int_ctrl #(
  parameter int nsrc = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     dataIn,
  input  logic [nsrc-1:0] irq,
  input  logic            intAck,
  output logic [31:0]     dataOut,
  output logic            EXL,
  output logic            IV
);

  localparam logic [4:0] ADDR_CTRL  = 5'b11000;
  localparam logic [4:0] ADDR_PEND  = 5'b11001;
  localparam logic [4:0] ADDR_CAUSE = 5'b11010;
  localparam logic [4:0] ADDR_EOI   = 5'b11011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_r;
  logic [nsrc-1:0] en_r;
  logic [nsrc-1:0] pend_r;
  logic [nsrc-1:0] irq_d_r;
  logic            gie_r;
  logic            ivm_r;
  logic            exl_r;
  logic [2:0]      id_r;

  logic [nsrc-1:0] rise_s;
  logic [nsrc-1:0] act_s;
  logic [nsrc-1:0] clr_s;
  logic [nsrc-1:0] id_sel_s;
  logic [nsrc-1:0] ack_clr_s;
  logic [nsrc-1:0] pend_nxt_s;
  logic            req_s;
  logic            pend_id_s;
  logic            wr_ctrl_s;
  logic            wr_pend_s;
  logic            wr_eoi_s;
  logic            ack_s;
  logic [31:0]     read_s;

  // Lowest set index wins.
  function automatic logic [2:0] prio_id(input logic [nsrc-1:0] vec);
    prio_id = 3'd0;
    for (int i = nsrc - 1; i >= 0; i--) begin
      if (vec[i]) prio_id = 3'(i);
    end
  endfunction

  // Write decode, edge detection and next pending state (a new edge beats any clear).
  always_comb begin
    wr_ctrl_s = we && (addr == ADDR_CTRL);
    wr_pend_s = we && (addr == ADDR_PEND);
    wr_eoi_s  = we && (addr == ADDR_EOI);
    ack_s     = (state_r == REQ) && intAck;
    rise_s    = irq & ~irq_d_r;
    act_s     = pend_r & en_r;
    req_s     = gie_r & (|act_s);
    for (int i = 0; i < nsrc; i++) begin
      id_sel_s[i]  = (id_r == 3'(i));
      ack_clr_s[i] = ack_s && (id_r == 3'(i));
    end
    pend_id_s = |(pend_r & id_sel_s);
    if (wr_pend_s) begin
      clr_s = dataIn[nsrc-1:0];
    end else begin
      clr_s = '0;
    end
    pend_nxt_s = (pend_r & ~clr_s & ~ack_clr_s) | rise_s;
  end

  // Configuration, pending and edge-history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r    <= '0;
      gie_r   <= 1'b0;
      ivm_r   <= 1'b0;
      pend_r  <= '0;
      irq_d_r <= '0;
    end else begin
      irq_d_r <= irq;
      pend_r  <= pend_nxt_s;
      if (wr_ctrl_s) begin
        en_r  <= dataIn[nsrc-1:0];
        gie_r <= dataIn[8];
        ivm_r <= dataIn[9];
      end
    end
  end

  // Request/service FSM; id is frozen once REQ is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      exl_r   <= 1'b0;
      id_r    <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            id_r    <= prio_id(act_s);
            state_r <= REQ;
            exl_r   <= 1'b1;
          end
        end
        REQ: begin
          if (intAck) begin
            state_r <= SERVICE;
            exl_r   <= 1'b0;
          end else if (!gie_r || !pend_id_s) begin
            state_r <= IDLE;
            exl_r   <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_eoi_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          exl_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; CAUSE shows an id only while one is requested or in service.
  always_comb begin
    read_s = 32'd0;
    case (addr)
      ADDR_CTRL: begin
        read_s[nsrc-1:0] = en_r;
        read_s[8]        = gie_r;
        read_s[9]        = ivm_r;
      end
      ADDR_PEND: begin
        read_s[nsrc-1:0] = pend_r;
      end
      ADDR_CAUSE: begin
        if (state_r != IDLE) begin
          read_s[2:0] = id_r;
        end else begin
          read_s[2:0] = 3'd0;
        end
        read_s[8] = (state_r == SERVICE);
        read_s[9] = exl_r;
      end
      default: begin
        read_s = 32'd0;
      end
    endcase
  end

  assign dataOut = read_s;
  assign EXL     = exl_r;
  assign IV      = ivm_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_int_ctrl;

  localparam logic [4:0] A_CTRL  = 5'b11000;
  localparam logic [4:0] A_PEND  = 5'b11001;
  localparam logic [4:0] A_CAUSE = 5'b11010;
  localparam logic [4:0] A_EOI   = 5'b11011;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] dataIn;
  logic [3:0]  irq;
  logic        intAck;
  logic [31:0] dataOut;
  logic        EXL;
  logic        IV;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model: phase 0 = idle, 1 = requesting, 2 = in service.
  int         m_phase;
  int         m_id;
  logic [3:0] m_en;
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic       m_gie;
  logic       m_ivm;

  int_ctrl #(.nsrc(4)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .dataIn(dataIn),
    .irq(irq), .intAck(intAck), .dataOut(dataOut), .EXL(EXL), .IV(IV)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_id = 0;
    m_en = 4'd0; m_pend = 4'd0; m_prev = 4'd0;
    m_gie = 1'b0; m_ivm = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == A_CTRL) v = {22'd0, m_ivm, m_gie, 4'd0, m_en};
    else if (a == A_PEND) v = {28'd0, m_pend};
    else if (a == A_CAUSE && m_phase != 0)
      v = {22'd0, (m_phase == 1), (m_phase == 2), 5'd0, 3'(m_id)};
    return v;
  endfunction

  // Apply the controller's rules for one clock edge to the current inputs.
  task automatic model_step();
    logic [3:0] rises;
    logic [3:0] act;
    rises = irq & ~m_prev;
    act   = m_pend & m_en;
    if (m_phase == 0) begin
      if (m_gie && act != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (act[i]) m_id = i;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (intAck) begin
        m_pend[m_id] = 1'b0;
        m_phase = 2;
      end else if (!m_gie || !m_pend[m_id]) begin
        m_phase = 0;
      end
    end else if (we && addr == A_EOI) begin
      m_phase = 0;
    end
    if (we && addr == A_CTRL) begin
      m_en = dataIn[3:0]; m_gie = dataIn[8]; m_ivm = dataIn[9];
    end
    if (we && addr == A_PEND) m_pend = m_pend & ~dataIn[3:0];
    m_pend = m_pend | rises;
    m_prev = irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("exl", {31'd0, EXL}, {31'd0, (m_phase == 1)});
    chk("iv", {31'd0, IV}, {31'd0, m_ivm});
    chk("dout", dataOut, model_read(addr));
    we = 1'b0;
    intAck = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; dataIn = d;
    step();
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a;
    #1;
    chk(tag, dataOut, exp);
    chk({tag, "_model"}, dataOut, model_read(a));
  endtask

  task automatic do_reset(input logic [3:0] irq_hold);
    irq = irq_hold;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_exl", {31'd0, EXL}, 32'd0);
    chk("rst_iv", {31'd0, IV}, 32'd0);
    chk("rst_dout", dataOut, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rel_exl", {31'd0, EXL}, 32'd0);
    rd("rel_ctrl", A_CTRL, 32'd0);
    rd("rel_pend", A_PEND, 32'd0);
    irq = 4'd0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; addr = 5'd0; dataIn = 32'd0; irq = 4'd0; intAck = 1'b0;
    do_reset(4'hF);
    step();

    // Basic flow
    wr(A_CTRL, 32'h101);
    irq = 4'b0001;
    step();
    chk("basic_exl_k", {31'd0, EXL}, 32'd0);
    step();
    chk("basic_exl", {31'd0, EXL}, 32'd1);
    rd("basic_cause_req", A_CAUSE, 32'h200);
    intAck = 1'b1;
    step();
    chk("basic_exl_ack", {31'd0, EXL}, 32'd0);
    rd("basic_cause_svc", A_CAUSE, 32'h100);
    rd("basic_pend", A_PEND, 32'h0);
    irq = 4'd0;
    wr(A_EOI, 32'h0);
    rd("basic_cause_eoi", A_CAUSE, 32'h0);

    // Priority: bit 1 beats bit 3, then bit 3 follows one cycle after EOI
    wr(A_CTRL, 32'h10F);
    irq = 4'b1010;
    step();
    step();
    rd("prio_cause1", A_CAUSE, 32'h201);
    intAck = 1'b1;
    step();
    rd("prio_svc1", A_CAUSE, 32'h101);
    wr(A_EOI, 32'h0);
    chk("prio_exl_eoi", {31'd0, EXL}, 32'd0);
    step();
    rd("prio_cause3", A_CAUSE, 32'h203);
    intAck = 1'b1;
    step();
    wr(A_EOI, 32'h0);
    irq = 4'd0;
    step();

    // Masking, then GIE cleared while requesting
    wr(A_CTRL, 32'h102);
    irq = 4'b0001;
    step();
    irq = 4'd0;
    step();
    rd("mask_pend", A_PEND, 32'h1);
    chk("mask_exl", {31'd0, EXL}, 32'd0);
    wr(A_CTRL, 32'h103);
    chk("mask_exl_wr", {31'd0, EXL}, 32'd0);
    step();
    chk("mask_exl_on", {31'd0, EXL}, 32'd1);
    rd("mask_cause", A_CAUSE, 32'h200);
    wr(A_CTRL, 32'h003);
    chk("gie_exl_q", {31'd0, EXL}, 32'd1);
    step();
    chk("gie_exl_drop", {31'd0, EXL}, 32'd0);
    rd("gie_pend", A_PEND, 32'h1);

    // Same-edge rise and W1C on bit 2: the set wins
    irq = 4'b0100;
    wr(A_PEND, 32'h4);
    rd("w1c_race", A_PEND, 32'h5);
    irq = 4'd0;
    wr(A_PEND, 32'hF);
    rd("w1c_clear", A_PEND, 32'h0);

    // Reset while in service
    wr(A_CTRL, 32'h101);
    irq = 4'b0001;
    step();
    step();
    intAck = 1'b1;
    step();
    rd("svc_cause", A_CAUSE, 32'h100);
    do_reset(4'b0001);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset(4'($urandom));
        step();
      end
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      case ($urandom_range(0, 4))
        0: addr = A_CTRL;
        1: addr = A_PEND;
        2: addr = A_CAUSE;
        3: addr = A_EOI;
        default: addr = 5'($urandom);
      endcase
      we = ($urandom_range(0, 3) == 0);
      dataIn = $urandom;
      dataIn[8] = ($urandom_range(0, 4) != 0);
      intAck = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller sitting directly upstream of the main decoder: it collects edge-triggered interrupt requests (timer flag, debounced push-buttons, spare lines), prioritises them, and drives the `EXL`/`IV` inputs that force the core's PC to the handler at 0x180. Software configures and acknowledges it through the same 5-bit register address / `we` / `dataIn` bus the timer uses. It supports one interrupt in service at a time, with no nesting.

## Interface
- `nsrc`, 4: number of interrupt sources, 1..8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `we`  in  1  register write strobe, sampled on `clk`.
- `addr`  in  5  register select.
- `dataIn`  in  32  write data.
- `irq`  in  nsrc  request lines, already synchronous to `clk`; bit 0 has highest priority.
- `intAck`  in  1  one-cycle pulse from the core on its first fetch at 0x180.
- `dataOut`  out  32  read data for `addr`, combinational.
- `EXL`  out  1  exception-level request to the main decoder.
- `IV`  out  1  vectored-mode flag to the main decoder.

## Operation
Registers are decoded from `addr`; unlisted addresses read 0 and ignore writes.
- 5'b11000 CTRL (R/W)
  - [nsrc-1:0] enable mask.
  - [8] GIE, the global enable.
  - [9] IVM, vectored mode. `IV` = IVM at all times.
- 5'b11001 PEND (R/W1C)
  - [nsrc-1:0] pending bits.
  - Writing 1 clears a bit; writing 0 has no effect.
- 5'b11010 CAUSE (RO)
  - [2:0] id of the source in service or requested.
  - [8] inService.
  - [9] EXL.
- 5'b11011 EOI (WO): any write ends service.

Edge detection
- `irq_d` is a registered copy of `irq`.
- `pend[i]` is set on any edge where `irq[i] & ~irq_d[i]`, regardless of the enable mask.
- If a set and a W1C clear hit the same bit on the same edge, the set wins.
- A line held high sets its pending bit only once.

Request condition: `req = GIE & |(pend & enable)`. The selected id is the lowest index in `pend & enable`.

FSM states: IDLE, REQ, SERVICE.
- IDLE
  - If `req`: latch `id` and go to REQ.
- REQ (`EXL`=1)
  - If `intAck`: clear `pend[id]` and go to SERVICE.
  - Else if GIE=0 or `pend[id]` was cleared by software: go to IDLE with `EXL` dropping; other pending bits are kept.
  - `id` is frozen in REQ. A higher-priority arrival does not re-arbitrate.
- SERVICE (`EXL`=0, inService=1)
  - New requests only accumulate in PEND.
  - An EOI write goes to IDLE.
  - `intAck` is ignored.
- EOI written in IDLE or REQ: ignored.
- `intAck` in IDLE: ignored.

Reset (`rst`=0, asynchronous)
- State goes to IDLE.
- CTRL, PEND, `irq_d` and `id` go to 0.
- Outputs: `EXL`=0, `IV`=0, `dataOut`=0.
- Reset asserted mid-REQ or mid-SERVICE discards everything in flight.

## Timing
- `EXL` is a registered output, decoded from the state flops with no combinational path from `irq`.
- `irq[i]` rising before edge k:
  - `pend[i]`=1 after edge k.
  - State REQ and `EXL`=1 after edge k+1, provided enabled and state was IDLE. The latency is 2 cycles.
- `intAck` high at edge m: `EXL`=0, inService=1 and `pend[id]`=0 after edge m.
- EOI write at edge p:
  - IDLE after edge p.
  - If `req` still holds, REQ and `EXL`=1 after edge p+1.
- CTRL and PEND writes take effect after the write edge. A GIE clear at edge q drops `EXL` after edge q+1.
- `dataOut` reflects register contents immediately after the edge that updated them.

## Test plan
- Reset: hold `rst`=0 with `irq`=4'hF. After release, `EXL`=0, PEND reads 0, CTRL reads 0.
- Basic flow:
  - Write CTRL=0x101, then pulse `irq[0]` before edge k: `EXL`=1 after edge k+1, CAUSE=0x200.
  - `intAck`: `EXL`=0, CAUSE=0x100, PEND=0.
  - EOI write: CAUSE=0.
- Priority: CTRL=0x10F, `irq[3]` and `irq[1]` rise together → `id`=1. After `intAck` + EOI, a second REQ follows with `id`=3, 1 cycle after EOI.
- Masking: CTRL=0x102, pulse `irq[0]` → PEND=0x1, `EXL` stays 0. Write CTRL=0x103 → `EXL`=1 one cycle later with `id`=0.
- Boundaries:
  - Same-edge `irq[2]` rise and W1C 0x4: PEND bit 2 stays 1.
  - GIE cleared in REQ: `EXL` drops and PEND is retained.
  - `rst` asserted in SERVICE: CAUSE=0 immediately.
